// File: rtl/dmtd_clk_gen_if.sv
// dmtd_clk_gen_if: configuration handshake bundle for dmtd_clk_gen.
// The master offers a period/phase pair with cfg_valid; the generator
// (slave) accepts it whenever cfg_ready is high.
interface dmtd_clk_gen_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_period;
    logic [DIV_W-1:0] cfg_phase;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/dmtd_clk_gen.sv
// dmtd_clk_gen: programmable two-phase test-clock generator feeding the
// DMTD measurement path. clk_a is a square wave of period P system clocks,
// clk_b is the same wave lagging by ph clocks, sync_pulse marks each clk_a
// period start. New period/phase settings are staged in a one-deep pending
// slot and take effect at a period boundary so clk_a is never shortened.
// Optional feature macro: DMTD_GEN_DRIFT_EN enables the drift phase walk.
module dmtd_clk_gen #(
    parameter int DIV_W      = 8,
    parameter int DEF_PERIOD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 drift,
    dmtd_clk_gen_if.slave        cfg,
    output logic                 clk_a,
    output logic                 clk_b,
    output logic                 sync_pulse
);

    localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEF_PERIOD);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [DIV_W-1:0] period_q, phase_q, cnt_a;
    logic [DIV_W-1:0] pend_p, pend_ph;
    logic             pend_v;
    logic             run_q;

    logic [DIV_W-1:0] p_new, ph_new;
    logic [DIV_W-1:0] cnt_next, period_next, phase_next, half_next;
    logic [DIV_W:0]   cnt_b_next;
    logic             accept, at_end, wrap, apply;
    logic             clk_a_next, clk_b_next, sync_next;

`ifdef DMTD_GEN_DRIFT_EN
    logic [DIV_W:0]   ph_inc;
    logic [DIV_W-1:0] ph_step;
`else
    logic             unused_drift;
    assign unused_drift = &{1'b0, drift};
`endif

    assign cfg.cfg_ready = !pend_v;

    // Next-state logic: sanitise requests, decide the period boundary,
    // pick the active setting and derive the registered outputs from it.
    always_comb begin
        p_new  = (cfg.cfg_period < TWO) ? TWO : cfg.cfg_period;
        ph_new = (cfg.cfg_phase >= p_new) ? (p_new - ONE) : cfg.cfg_phase;

        accept = cfg.cfg_valid && !pend_v;
        // at_end: last cycle of a running period; the first enabled edge
        // after a stop also starts a fresh period at count 0.
        at_end = run_q && (cnt_a == (period_q - ONE));
        wrap   = enable && (!run_q || at_end);
        apply  = pend_v && (wrap || !enable);

        cnt_next = '0;
        if (enable && !wrap) begin
            cnt_next = cnt_a + ONE;
        end

        period_next = apply ? pend_p  : period_q;
        phase_next  = apply ? pend_ph : phase_q;

`ifdef DMTD_GEN_DRIFT_EN
        ph_inc  = {1'b0, phase_q} + {1'b0, ONE};
        ph_step = (ph_inc == {1'b0, period_q}) ? '0 : ph_inc[DIV_W-1:0];
        if (!apply && enable && at_end && drift) begin
            phase_next = ph_step;
        end
`endif

        cnt_b_next = {1'b0, cnt_next} - {1'b0, phase_next};
        if (cnt_b_next[DIV_W]) begin
            cnt_b_next = cnt_b_next + {1'b0, period_next};
        end

        half_next  = period_next >> 1;
        clk_a_next = enable && (cnt_next < half_next);
        clk_b_next = enable && (cnt_b_next < {1'b0, half_next});
        sync_next  = enable && (cnt_next == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q   <= DEF_P;
            phase_q    <= '0;
            cnt_a      <= '0;
            run_q      <= 1'b0;
            pend_v     <= 1'b0;
            pend_p     <= DEF_P;
            pend_ph    <= '0;
            clk_a      <= 1'b0;
            clk_b      <= 1'b0;
            sync_pulse <= 1'b0;
        end else begin
            period_q   <= period_next;
            phase_q    <= phase_next;
            cnt_a      <= cnt_next;
            run_q      <= enable;
            if (apply) begin
                pend_v <= 1'b0;
            end else if (accept) begin
                pend_v  <= 1'b1;
                pend_p  <= p_new;
                pend_ph <= ph_new;
            end
            clk_a      <= clk_a_next;
            clk_b      <= clk_b_next;
            sync_pulse <= sync_next;
        end
    end

endmodule

// File: tb/tb_dmtd_clk_gen.sv
// tb_dmtd_clk_gen: directed scenarios followed by randomized traffic,
// every cycle compared against a period/position reference model.
module tb_dmtd_clk_gen;

    localparam int DIV_W      = 8;
    localparam int DEF_PERIOD = 10;

`ifdef DMTD_GEN_DRIFT_EN
    localparam bit DRIFT_ON = 1'b1;
`else
    localparam bit DRIFT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, enable, drift;
    logic clk_a, clk_b, sync_pulse;

    dmtd_clk_gen_if #(.DIV_W(DIV_W)) cfg_if ();

    dmtd_clk_gen #(
        .DIV_W      (DIV_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .drift      (drift),
        .cfg        (cfg_if),
        .clk_a      (clk_a),
        .clk_b      (clk_b),
        .sync_pulse (sync_pulse)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: active period/lag, position inside the current
    // period (-1 while stopped) and the one-deep pending slot.
    int m_p, m_ph, m_pos, m_pend_p, m_pend_ph;
    bit m_pend_v;

    // Compare one observed value with its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic modelStep(input bit r, input bit en, input bit v,
                             input int per, input int ph, input bit dr);
        bit take;
        int np, nph;
        take = v && !m_pend_v;
        np   = (per < 2) ? 2 : per;
        nph  = (ph >= np) ? np - 1 : ph;
        if (r) begin
            m_p = DEF_PERIOD; m_ph = 0; m_pos = -1; m_pend_v = 1'b0;
            return;
        end
        if (!en) begin
            m_pos = -1;
            if (m_pend_v) begin
                m_p = m_pend_p; m_ph = m_pend_ph; m_pend_v = 1'b0;
            end
        end else if (m_pos == -1 || m_pos == m_p - 1) begin
            if (m_pend_v) begin
                m_p = m_pend_p; m_ph = m_pend_ph; m_pend_v = 1'b0;
            end else if (DRIFT_ON && dr && m_pos != -1) begin
                m_ph = (m_ph + 1) % m_p;
            end
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (take) begin
            m_pend_v = 1'b1; m_pend_p = np; m_pend_ph = nph;
        end
    endtask

    // Drive one cycle of inputs, step the model and check after the edge.
    task automatic applyStimulus(input bit r, input bit en, input bit v,
                                 input int per, input int ph, input bit dr);
        logic [31:0] per_l, ph_l;
        bit ea, eb, es;
        per_l = per;
        ph_l  = ph;
        rst                = r;
        enable             = en;
        drift              = dr;
        cfg_if.cfg_valid   = v;
        cfg_if.cfg_period  = per_l[DIV_W-1:0];
        cfg_if.cfg_phase   = ph_l[DIV_W-1:0];
        modelStep(r, en, v, per, ph, dr);
        ea = (m_pos >= 0) && (m_pos < m_p / 2);
        eb = (m_pos >= 0) && (((m_pos - m_ph + m_p) % m_p) < m_p / 2);
        es = (m_pos == 0);
        @(posedge clk);
        #1;
        checkOutput("clk_a",      {31'd0, clk_a},            {31'd0, ea});
        checkOutput("clk_b",      {31'd0, clk_b},            {31'd0, eb});
        checkOutput("sync_pulse", {31'd0, sync_pulse},       {31'd0, es});
        checkOutput("cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, !m_pend_v});
    endtask

    initial begin
        int guard;
        m_p = DEF_PERIOD; m_ph = 0; m_pos = -1; m_pend_v = 1'b0;
        m_pend_p = DEF_PERIOD; m_pend_ph = 0;

        // Reset, then the default 10-cycle wave with drift requested.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 45; i++) applyStimulus(0, 1, 0, 0, 0, 1);

        // Lag of 3 cycles.
        applyStimulus(0, 1, 1, 10, 3, 0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0, 0, 0);

        // Mid-period change to P=7.
        applyStimulus(0, 1, 1, 7, 0, 0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, 0, 0, 0, 0);

        // Clamping: P=1/ph=5 and then ph=12 with P=10.
        applyStimulus(0, 1, 1, 1, 5, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 10, 12, 0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, 0, 0, 0, 0);

        // Reset at count 6 with a configuration pending.
        guard = 0;
        while (m_pos != 2 && guard < 40) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            guard++;
        end
        checkOutput("reach_pos2", guard < 40, 1);
        applyStimulus(0, 1, 1, 4, 1, 0);
        guard = 0;
        while (m_pos != 5 && guard < 40) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            guard++;
        end
        checkOutput("reach_pos5", guard < 40, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0, 0, 0);

        // Stop and restart.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 19) != 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 20),
                          $urandom_range(0, 25),
                          $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
